rail_sequencer: RTL and testbench

RAIL_SEQUENCER -- requirements
Module: rail_sequencer

---
 rtl/rail_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_rail_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rail_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rail_sequencer                                               |
// | Description : Ordered power-up / reverse-order power-down of five supply   |
// |               rails with per-rail power-good timeout and a latched fault.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rail_sequencer #(
  parameter int STEP_DELAY = 1000,
  parameter int PG_TIMEOUT = 100000,
  parameter int OFF_DELAY  = 1000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       clear_fault,
  input  logic [4:0] pg,
  output logic [4:0] act_ctl,
  output logic       all_good,
  output logic       fault,
  output logic [2:0] fault_rail,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_STEP = 3'd1;
  localparam logic [2:0] S_WAIT_PG   = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_SHUTDOWN  = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  // Terminal counts: each delay of N cycles ends when the counter reads N-1.
  localparam logic [23:0] STEP_LAST = 24'(STEP_DELAY - 1);
  localparam logic [23:0] PG_LAST   = 24'(PG_TIMEOUT - 1);
  localparam logic [23:0] OFF_LAST  = 24'(OFF_DELAY - 1);
  localparam logic [2:0]  LAST_RAIL = 3'd4;

  logic [23:0] counter;
  logic [2:0]  idx;

  logic [2:0]  state_next;
  logic [23:0] counter_next;
  logic [2:0]  idx_next;
  logic [4:0]  act_next;
  logic        all_good_next;
  logic        fault_next;
  logic [2:0]  fault_rail_next;

  logic [7:0]  pg_pad;
  logic        pg_sel;
  logic        pg_all;
  logic [2:0]  lowest_low;
  logic [2:0]  highest_act;
  logic        step_done;
  logic        pg_expired;
  logic        off_done;

  // Padding lets idx address pg without an out-of-range select.
  assign pg_pad     = {3'b000, pg};
  assign pg_sel     = pg_pad[idx];
  assign pg_all     = &pg;
  assign step_done  = (counter == STEP_LAST);
  assign pg_expired = (counter == PG_LAST);
  assign off_done   = (counter == OFF_LAST);

  // Priority encoders: lowest rail reporting not-good, highest rail enabled.
  always_comb begin
    lowest_low  = 3'd0;
    highest_act = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (!pg[i]) lowest_low = 3'(i);
    end
    for (int i = 0; i < 5; i++) begin
      if (act_ctl[i]) highest_act = 3'(i);
    end
  end

  // State, counter and rail index registers plus registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      counter    <= 24'd0;
      idx        <= 3'd0;
      act_ctl    <= 5'd0;
      all_good   <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= 3'd0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      idx        <= idx_next;
      act_ctl    <= act_next;
      all_good   <= all_good_next;
      fault      <= fault_next;
      fault_rail <= fault_rail_next;
    end
  end

  // Next-state logic: sequencing decisions, counter and rail index updates.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    idx_next     = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_next     = 3'd0;
          counter_next = 24'd0;
          state_next   = S_WAIT_STEP;
        end
      end
      S_WAIT_STEP: begin
        // A dropped request outranks the step timer.
        if (!start) begin
          counter_next = 24'd0;
          if (act_ctl == 5'd0) begin
            idx_next   = 3'd0;
            state_next = S_IDLE;
          end else begin
            idx_next   = highest_act;
            state_next = S_SHUTDOWN;
          end
        end else if (step_done) begin
          counter_next = 24'd0;
          state_next   = S_WAIT_PG;
        end else begin
          counter_next = counter + 24'd1;
        end
      end
      S_WAIT_PG: begin
        // Abort first, then power-good (wins a tie with the timeout).
        if (!start) begin
          counter_next = 24'd0;
          if (act_ctl == 5'd0) begin
            idx_next   = 3'd0;
            state_next = S_IDLE;
          end else begin
            idx_next   = highest_act;
            state_next = S_SHUTDOWN;
          end
        end else if (pg_sel) begin
          counter_next = 24'd0;
          if (idx == LAST_RAIL) begin
            state_next = S_RUN;
          end else begin
            idx_next   = idx + 3'd1;
            state_next = S_WAIT_STEP;
          end
        end else if (pg_expired) begin
          state_next = S_FAULT;
        end else begin
          counter_next = counter + 24'd1;
        end
      end
      S_RUN: begin
        if (!pg_all) begin
          state_next = S_FAULT;
        end else if (!start) begin
          idx_next     = LAST_RAIL;
          counter_next = 24'd0;
          state_next   = S_SHUTDOWN;
        end
      end
      S_SHUTDOWN: begin
        if (off_done) begin
          counter_next = 24'd0;
          if (idx == 3'd0) begin
            state_next = S_IDLE;
          end else begin
            idx_next = idx - 3'd1;
          end
        end else begin
          counter_next = counter + 24'd1;
        end
      end
      S_FAULT: begin
        if (clear_fault && !start) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next   = S_IDLE;
        counter_next = 24'd0;
        idx_next     = 3'd0;
      end
    endcase
  end

  // Output logic: rail enables and fault flags change only on transitions.
  always_comb begin
    act_next        = act_ctl;
    fault_next      = fault;
    fault_rail_next = fault_rail;
    all_good_next   = (state_next == S_RUN);
    if ((state_next == S_FAULT) && (state != S_FAULT)) begin
      act_next        = 5'd0;
      fault_next      = 1'b1;
      fault_rail_next = (state == S_RUN) ? lowest_low : idx;
    end else if ((state == S_WAIT_STEP) && (state_next == S_WAIT_PG)) begin
      act_next = act_ctl | (5'b00001 << idx);
    end else if ((state == S_SHUTDOWN) && off_done) begin
      act_next = act_ctl & ~(5'b00001 << idx);
    end else if ((state == S_FAULT) && (state_next == S_IDLE)) begin
      fault_next      = 1'b0;
      fault_rail_next = 3'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rail_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rail_sequencer                                            |
// | Description : Scenario generator, event scoreboard and monitor for the     |
// |               five-rail power sequencer.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rail_sequencer;

  localparam int S = 4;
  localparam int P = 16;
  localparam int O = 3;
  localparam int INF = 100000;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       clear_fault = 1'b0;
  logic [4:0] pg = 5'd0;
  logic [4:0] act_ctl;
  logic       all_good;
  logic       fault;
  logic [2:0] fault_rail;
  logic [2:0] state;

  rail_sequencer #(
    .STEP_DELAY(S),
    .PG_TIMEOUT(P),
    .OFF_DELAY (O)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .clear_fault(clear_fault),
    .pg         (pg),
    .act_ctl    (act_ctl),
    .all_good   (all_good),
    .fault      (fault),
    .fault_rail (fault_rail),
    .state      (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One expected change of the observable outputs; edge_n < 0 means "any cycle".
  typedef struct {
    int         edge_n;
    logic [2:0] st;
    logic [4:0] act;
    logic       flt;
    logic [2:0] frail;
    logic       ag;
  } ev_t;

  ev_t sb_q[$];
  ev_t gen_q[$];

  logic       st_a  [0:511];
  logic [4:0] pg_a  [0:511];
  logic       clr_a [0:511];
  int         gen_len;

  int         k_mode, k_lag, k_to_rail, k_abort, k_dwell;
  logic [4:0] k_drop;

  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;
  logic [12:0] cur, prev;
  ev_t want;

  task automatic chk(input string name, input int got, input int exp_v);
    vectors++;
    if (got != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
    end
  endtask

  // Monitor: every change of the outputs must match the next expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {state, act_ctl, fault, fault_rail, all_good};
      if (cur !== prev) begin
        prev = cur;
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cycle=%0d: got state=%0d act=%b fault=%0d rail=%0d all_good=%0d, expected no change",
                   cyc, state, act_ctl, fault, fault_rail, all_good);
        end else begin
          want = sb_q.pop_front();
          if ((cur !== {want.st, want.act, want.flt, want.frail, want.ag}) ||
              ((want.edge_n >= 0) && (want.edge_n != cyc))) begin
            miscompares++;
            $display("FAIL event: got cycle=%0d state=%0d act=%b fault=%0d rail=%0d all_good=%0d, expected cycle=%0d state=%0d act=%b fault=%0d rail=%0d all_good=%0d",
                     cyc, state, act_ctl, fault, fault_rail, all_good,
                     want.edge_n, want.st, want.act, want.flt, want.frail, want.ag);
          end
        end
      end
    end
  end

  task automatic add_ev(input int r, input int st, input logic [4:0] act,
                        input int flt, input int frail, input int ag);
    ev_t e;
    e.edge_n = r;
    e.st     = 3'(st);
    e.act    = act;
    e.flt    = 1'(flt);
    e.frail  = 3'(frail);
    e.ag     = 1'(ag);
    gen_q.push_back(e);
  endtask

  function automatic int pick_lag(input int i);
    int r;
    if (i == k_to_rail) return P + 1 + int'($urandom_range(0, 2));
    if (k_lag > 0) return k_lag;
    r = int'($urandom_range(0, 9));
    if (r == 0) return P;
    if (r == 1) return P + 1;
    return int'($urandom_range(1, P - 1));
  endfunction

  function automatic int first_zero(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (!v[i]) return i;
    return 0;
  endfunction

  // Fault latched at edge f: ignored clear with start=1, then a real clear.
  task automatic do_clear(input int f, output int end_r);
    int c1, c2;
    c1 = f + 1 + int'($urandom_range(0, 3));
    c2 = c1 + 1 + int'($urandom_range(0, 3));
    for (int r = f + 1; r <= c1; r++) st_a[r] = 1'b1;
    clr_a[c1] = 1'b1;
    clr_a[c2] = 1'b1;
    add_ev(c2, 0, 5'd0, 0, 0, 0);
    end_r = c2;
  endtask

  // Builds one scenario: per-edge stimulus (relative to its start) and the
  // expected output changes, derived from rail timing arithmetic.
  task automatic gen();
    int pg_on [5];
    int x, e, a, l, t, f, frail, outcome, run_r, end_r, h, j;
    logic [4:0] m, drop;
    gen_q.delete();
    for (int r = 0; r < 512; r++) begin
      st_a[r] = 1'b0; pg_a[r] = 5'd0; clr_a[r] = 1'b0;
    end
    for (int i = 0; i < 5; i++) pg_on[i] = INF;
    x = INF;
    if (k_mode == 2) x = (k_abort > 0) ? k_abort : 2 + int'($urandom_range(0, 5 * (S + P / 2)));
    add_ev(1, 1, 5'd0, 0, 0, 0);
    e = 1; m = 5'd0; outcome = 0; run_r = 0; f = 0; frail = 0;
    for (int i = 0; i < 5; i++) begin
      if (x <= e + S) begin outcome = 1; break; end
      a = e + S;
      m = m | (5'b00001 << i);
      add_ev(a, 2, m, 0, 0, 0);
      l = pick_lag(i);
      pg_on[i] = a + l;
      if (x <= a + ((l < P) ? l : P)) begin outcome = 1; break; end
      if (l <= P) begin
        if (i < 4) begin
          e = a + l;
          add_ev(e, 1, m, 0, 0, 0);
        end else begin
          run_r = a + l;
          add_ev(run_r, 3, m, 0, 0, 1);
        end
      end else begin
        f = a + P; frail = i; outcome = 2; break;
      end
    end
    for (int r = 0; r < 512; r++)
      for (int i = 0; i < 5; i++)
        if (r >= pg_on[i]) pg_a[r][i] = 1'b1;
    end_r = 0;
    if (outcome == 1) begin
      for (int r = 1; r < x; r++) st_a[r] = 1'b1;
      if (m == 5'd0) begin
        add_ev(x, 0, 5'd0, 0, 0, 0);
        end_r = x;
      end else begin
        h = 0;
        for (int i = 0; i < 5; i++) if (m[i]) h = i;
        add_ev(x, 4, m, 0, 0, 0);
        for (int k = h; k >= 0; k--) begin
          m[k] = 1'b0;
          add_ev(x + O * (h - k + 1), (k == 0) ? 0 : 4, m, 0, 0, 0);
        end
        end_r = x + O * (h + 1);
      end
    end else if (outcome == 2) begin
      for (int r = 1; r <= f; r++) st_a[r] = 1'b1;
      add_ev(f, 5, 5'd0, 1, frail, 0);
      do_clear(f, end_r);
    end else begin
      t = run_r + ((k_dwell > 0) ? k_dwell : int'($urandom_range(1, 8)));
      for (int r = 1; r < t; r++) st_a[r] = 1'b1;
      if ((k_mode == 1) || ((k_mode == 2) && ($urandom_range(0, 1) == 1))) begin
        drop = (k_drop != 5'd0) ? k_drop : 5'($urandom);
        if (drop == 5'h1f) drop[$urandom_range(0, 4)] = 1'b0;
        for (int r = t; r < 512; r++) pg_a[r] = drop;
        st_a[t] = 1'($urandom_range(0, 1));
        add_ev(t, 5, 5'd0, 1, first_zero(drop), 0);
        do_clear(t, end_r);
      end else begin
        m = 5'h1f;
        add_ev(t, 4, m, 0, 0, 0);
        for (int k = 4; k >= 0; k--) begin
          m[k] = 1'b0;
          add_ev(t + O * (5 - k), (k == 0) ? 0 : 4, m, 0, 0, 0);
        end
        end_r = t + 5 * O;
        if ($urandom_range(0, 1) == 1)
          for (int r = t + 2; r <= t + 5; r++) st_a[r] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          j = int'($urandom_range(1, 12));
          drop = 5'($urandom);
          for (int r = t + j; r < 512; r++) pg_a[r] = drop;
        end
      end
    end
    gen_len = end_r + 2;
  endtask

  // Plays the generated scenario; stop > 0 truncates it for the reset test.
  task automatic play(input int stop, output int base);
    ev_t e;
    int  n;
    @(posedge clk);
    #1;
    base = cyc;
    foreach (gen_q[k]) begin
      e = gen_q[k];
      e.edge_n = e.edge_n + base;
      sb_q.push_back(e);
    end
    n = (stop > 0) ? stop : gen_len;
    for (int r = 1; r <= n; r++) begin
      start = st_a[r]; pg = pg_a[r]; clear_fault = clr_a[r];
      @(posedge clk);
      #1;
    end
    if (stop == 0) begin
      start = 1'b0; pg = 5'd0; clear_fault = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic set_knobs(input int mode, input int lag, input int to_rail,
                           input int abort_x, input int dwell, input logic [4:0] drop);
    k_mode = mode; k_lag = lag; k_to_rail = to_rail;
    k_abort = abort_x; k_dwell = dwell; k_drop = drop;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_act", int'(act_ctl), 0);
    chk("reset_flags", int'({fault, fault_rail, all_good}), 0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_release", int'(state), 0);
    prev = 13'd0;
    mon_en = 1'b1;

    set_knobs(0, 2, -1, 0, 3, 5'd0);        gen(); play(0, base);
    set_knobs(0, 2, 2, 0, 0, 5'd0);         gen(); play(0, base);
    set_knobs(1, 2, -1, 0, 2, 5'b10101);    gen(); play(0, base);
    set_knobs(2, 2, -1, 12, 0, 5'd0);       gen(); play(0, base);
    set_knobs(0, P, -1, 0, 1, 5'd0);        gen(); play(0, base);
    set_knobs(2, 2, -1, 3, 0, 5'd0);        gen(); play(0, base);

    for (int n = 0; n < 40; n++) begin
      set_knobs(int'($urandom_range(0, 2)), 0, -1, 0, 0, 5'd0);
      gen();
      play(0, base);
    end

    // Reset while in RUN: rails drop at once, no reverse-order shutdown.
    set_knobs(0, 2, -1, 0, 6, 5'd0);
    gen();
    play(34, base);
    @(negedge clk);
    #2;
    while ((sb_q.size() > 0) && (sb_q[$].edge_n > base + 34)) void'(sb_q.pop_back());
    begin
      ev_t e;
      e.edge_n = -1; e.st = 3'd0; e.act = 5'd0; e.flt = 1'b0; e.frail = 3'd0; e.ag = 1'b0;
      sb_q.push_back(e);
    end
    n_rst = 1'b0;
    #1;
    chk("async_reset_act", int'(act_ctl), 0);
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_all_good", int'(all_good), 0);
    start = 1'b0; pg = 5'd0; clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_queue_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
